// File: rtl/vjtag_dr_ctrl.sv
// Virtual-JTAG DR controller: BYPASS/ID/WRITE/READ channels over a tck-clocked DR scan.
// Latency: write strobe one clk after UDR, read request combinational at CDR; no backpressure (host paces via TAP).
module vjtag_dr_ctrl #(
    parameter int          IR_WIDTH   = 6,
    parameter int          DATA_WIDTH = 32,
    parameter int          NB_CH      = 4,
    parameter logic [31:0] ID_VALUE   = 32'h0000_CAFE,
    localparam int         CH_W       = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tdi,
    output logic                  tdo,
    input  logic [IR_WIDTH-1:0]   ir_in,
    output logic [IR_WIDTH-1:0]   ir_out,
    input  logic                  virtual_state_cdr,
    input  logic                  virtual_state_sdr,
    input  logic                  virtual_state_udr,
    input  logic                  virtual_state_cir,
    output logic                  wr_valid_o,
    output logic [CH_W-1:0]       wr_ch_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  rd_req_o,
    output logic [CH_W-1:0]       rd_ch_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  err_o
);

    localparam logic [1:0] OP_BYP = 2'b00;
    localparam logic [1:0] OP_ID  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;
    localparam logic [1:0] OP_RD  = 2'b11;
    localparam int         CNT_W  = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] ID_WORD = DATA_WIDTH'(ID_VALUE);

    logic [1:0]            op_raw;
    logic [IR_WIDTH-3:0]   ch_field;
    logic                  ch_ok;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] sr;
    logic                  bypass;
    logic [CNT_W-1:0]      cnt;
    logic [IR_WIDTH-2:0]   wr_cnt;

    // CIR needs no action: ir_out is refreshed every clk so it is always current.
    logic unused_cir;
    assign unused_cir = virtual_state_cir;

    assign op_raw   = ir_in[IR_WIDTH-1 -: 2];
    assign ch_field = ir_in[IR_WIDTH-3:0];
    assign ch_ok    = (int'(ch_field) < NB_CH);

    // Data ops addressing a non-existent channel degrade to BYPASS.
    always_comb begin
        op = op_raw;
        if ((op_raw == OP_WR || op_raw == OP_RD) && !ch_ok)
            op = OP_BYP;
    end

    assign tdo      = (op == OP_BYP) ? bypass : sr[0];
    assign rd_req_o = virtual_state_cdr && (op == OP_RD);
    assign rd_ch_o  = ch_field[CH_W-1:0];

    // Shift path: CDR load takes priority over a coincident SDR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr     <= '0;
            bypass <= 1'b0;
            cnt    <= '0;
        end else if (virtual_state_cdr) begin
            cnt    <= '0;
            bypass <= 1'b0;
            case (op)
                OP_ID:   sr <= ID_WORD;
                OP_RD:   sr <= rd_data_i;
                OP_WR:   sr <= wr_data_o;
                default: sr <= sr;
            endcase
        end else if (virtual_state_sdr) begin
            sr     <= {tdi, sr[DATA_WIDTH-1:1]};
            bypass <= tdi;
            if (cnt != CNT_SAT)
                cnt <= cnt + 1'b1;
        end
    end

    // Commit path: a write is accepted only when exactly DATA_WIDTH bits were shifted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid_o <= 1'b0;
            wr_ch_o    <= '0;
            wr_data_o  <= '0;
            wr_cnt     <= '0;
            err_o      <= 1'b0;
            ir_out     <= '0;
        end else begin
            wr_valid_o <= 1'b0;
            ir_out     <= {err_o, wr_cnt};
            if (virtual_state_udr && op == OP_WR) begin
                if (cnt == CNT_FULL) begin
                    wr_valid_o <= 1'b1;
                    wr_data_o  <= sr;
                    wr_ch_o    <= ch_field[CH_W-1:0];
                    wr_cnt     <= wr_cnt + 1'b1;
                end else begin
                    err_o      <= 1'b1;
                end
            end else if (virtual_state_udr && op == OP_ID) begin
                err_o <= 1'b0;
            end
        end
    end

endmodule
